// File: rtl/gvc_pkg.sv
// Shared types and constants for the gate vector checker.
// Consumed by gate_vector_checker and gate_ref_model.
package gvc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } gvc_state_e;

    localparam int unsigned FN_OR  = 0;
    localparam int unsigned FN_AND = 1;
    localparam int unsigned FN_XOR = 2;
    localparam int unsigned FN_NOR = 3;

    // One extra bit so a sweep where every vector fails still fits.
    function automatic int unsigned err_width(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden function for the gate under test.
// FUNC selects OR, AND, XOR or NOR over all N_IN inputs.
module gate_ref_model
    import gvc_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned FUNC = FN_OR
) (
    input  logic [N_IN-1:0] vec,
    output logic            y
);

    always_comb begin
        y = |vec;
        case (FUNC)
            FN_AND:  y = &vec;
            FN_XOR:  y = ^vec;
            FN_NOR:  y = ~(|vec);
            default: y = |vec;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus/response checker for a small combinational gate.
// Optional first-failure capture is enabled by defining GVC_FIRST_FAIL_EN.
module gate_vector_checker
    import gvc_pkg::*;
#(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned FUNC          = FN_OR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [N_IN-1:0]            vec_out,
    output logic                       vec_valid,
    input  logic                       dut_y,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
`ifdef GVC_FIRST_FAIL_EN
    output logic                       fail_seen,
    output logic [N_IN-1:0]            fail_vec,
`endif
    output logic [err_width(N_IN)-1:0] err_count
);

    localparam int unsigned EW = err_width(N_IN);
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    gvc_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [EW-1:0]   err_q, err_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            exp_y;
    logic            mismatch;
    logic            launch;

    gate_ref_model #(
        .N_IN (N_IN),
        .FUNC (FUNC)
    ) u_ref (
        .vec (vec_q),
        .y   (exp_y)
    );

    assign mismatch = (state_q == StCheck) && (dut_y != exp_y);
    assign launch   = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                // done/pass are set from the settled err_count one edge after entering StDone
                if (state_q == StDone) begin
                    done_d = 1'b1;
                    pass_d = (err_q == '0);
                end
                if (launch) begin
                    state_d = StSettle;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                end
                if (vec_q == VEC_LAST) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef GVC_FIRST_FAIL_EN
    logic            fseen_q, fseen_d;
    logic [N_IN-1:0] fvec_q, fvec_d;

    always_comb begin
        fseen_d = fseen_q;
        fvec_d  = fvec_q;
        if (launch) begin
            fseen_d = 1'b0;
            fvec_d  = '0;
        end else if (mismatch && !fseen_q) begin
            fseen_d = 1'b1;
            fvec_d  = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fseen_q <= 1'b0;
            fvec_q  <= '0;
        end else begin
            fseen_q <= fseen_d;
            fvec_q  <= fvec_d;
        end
    end

    assign fail_seen = fseen_q;
    assign fail_vec  = fvec_q;
`endif

endmodule
